// File: rtl/dmem_access_unit_pkg.sv
// Shared RV32I memory-access types used by the MEM-stage data access engine.
package rv32i_types;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/dmem_access_unit_align.sv
// Combinational width decode: byte-enable mask, lane-shifted store data and
// misalignment detection for one load/store.
module dmem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] store_data,
    output logic [3:0]  mask,
    output logic [31:0] shifted_data,
    output logic        misaligned
);

    // Unknown width codes fall through to word handling so they still trap
    // on any non-zero offset rather than silently issuing a partial access.
    always_comb begin
        mask       = 4'b0000;
        misaligned = 1'b0;
        if (mem_op == MEM_LOAD) begin
            case (load_funct3_t'(funct3))
                lb, lbu: mask = 4'b0001 << addr_lsb;
                lh, lhu: begin
                    mask       = 4'b0011 << addr_lsb;
                    misaligned = addr_lsb[0];
                end
                default: begin
                    mask       = 4'b1111;
                    misaligned = (addr_lsb != 2'b00);
                end
            endcase
        end else if (mem_op == MEM_STORE) begin
            case (store_funct3_t'(funct3))
                sb: mask = 4'b0001 << addr_lsb;
                sh: begin
                    mask       = 4'b0011 << addr_lsb;
                    misaligned = addr_lsb[0];
                end
                default: begin
                    mask       = 4'b1111;
                    misaligned = (addr_lsb != 2'b00);
                end
            endcase
        end
    end

    assign shifted_data = store_data << {addr_lsb, 3'b000};

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data access engine: issues one cache request per load/store,
// stalls the pipeline until the response, and holds the result until advance.
module dmem_access_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        advance,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_en,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] mem_rdata_out,
    output logic [3:0]  rmask_out,
    output logic [3:0]  wmask_out,
    output logic [31:0] write_data_out,
    output logic [1:0]  bit_shift_out,
    output logic        trap_out,
    output logic        stall_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  mask_q;
    logic [1:0]  shift_q;

    logic [3:0]  alignMask;
    logic [31:0] alignData;
    logic        misaligned;
    logic        isLoad;
    logic        isStore;
    logic        accept;

    dmem_align u_align (
        .funct3       (funct3),
        .mem_op       (mem_op),
        .addr_lsb     (addr[1:0]),
        .store_data   (store_data),
        .mask         (alignMask),
        .shifted_data (alignData),
        .misaligned   (misaligned)
    );

    assign isLoad  = valid_in && (mem_op == MEM_LOAD);
    assign isStore = valid_in && (mem_op == MEM_STORE);
    assign accept  = (isLoad || isStore) && !misaligned;

    // Responses are only honoured in BUSY, so a reset mid-request drops any late reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MEM_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        op_q    <= mem_op_t'(mem_op);
                        addr_q  <= {addr[31:2], 2'b00};
                        wdata_q <= alignData;
                        mask_q  <= alignMask;
                        shift_q <= addr[1:0];
                        rdata_q <= '0;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        rdata_q <= (op_q == MEM_LOAD) ? dmem_rdata : 32'h0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (advance) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_read      = 1'b0;
        dmem_write     = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        dmem_byte_en   = '0;
        mem_rdata_out  = '0;
        rmask_out      = '0;
        wmask_out      = '0;
        write_data_out = '0;
        bit_shift_out  = '0;
        trap_out       = 1'b0;
        stall_out      = 1'b0;
        case (state_q)
            IDLE: begin
                stall_out = accept;
                trap_out  = (isLoad || isStore) && misaligned;
                if (isLoad || isStore) begin
                    bit_shift_out = addr[1:0];
                end
                if (accept) begin
                    rmask_out      = isLoad  ? alignMask : 4'b0000;
                    wmask_out      = isStore ? alignMask : 4'b0000;
                    write_data_out = isStore ? alignData : 32'h0;
                end
            end
            default: begin
                stall_out      = (state_q == BUSY);
                dmem_read      = (state_q == BUSY) && (op_q == MEM_LOAD);
                dmem_write     = (state_q == BUSY) && (op_q == MEM_STORE);
                if (state_q == BUSY) begin
                    dmem_addr    = addr_q;
                    dmem_wdata   = wdata_q;
                    dmem_byte_en = mask_q;
                end
                mem_rdata_out  = rdata_q;
                rmask_out      = (op_q == MEM_LOAD)  ? mask_q  : 4'b0000;
                wmask_out      = (op_q == MEM_STORE) ? mask_q  : 4'b0000;
                write_data_out = (op_q == MEM_STORE) ? wdata_q : 32'h0;
                bit_shift_out  = shift_q;
            end
        endcase
    end

endmodule
